// File: rtl/zynet_sample_runner.sv
`default_nettype none
// ============================================================================
// Module   : zynet_sample_runner
// Brief    : Streams stored samples into zyNet, reads back the detected class
//            over AXI-lite and keeps right/wrong/sample counters.
// Revision : 1.0
// ============================================================================
module zynet_sample_runner #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_INPUTS     = 1024,
    parameter int MEM_ADDR_W     = 20,
    parameter int RESULT_ADDR    = 8,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           num_samples,
    input  logic                  stop_on_mismatch,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  intr,
    output logic [31:0]           m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           sample_count,
    output logic [15:0]           right_count,
    output logic [15:0]           wrong_count,
    output logic [31:0]           last_detected,
    output logic [DATA_WIDTH-1:0] last_expected,
    output logic                  mismatch
);
    localparam int c_CNT_W = $clog2(NUM_INPUTS + 1);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]    c_N         = c_CNT_W'(NUM_INPUTS);
    localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'(NUM_INPUTS - 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_LAST  = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MEM_ADDR_W-1:0] c_STRIDE    = MEM_ADDR_W'(NUM_INPUTS + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_GAP       = 4'd1,
        S_STREAM    = 4'd2,
        S_FETCH_EXP = 4'd3,
        S_WAIT_INTR = 4'd4,
        S_AR        = 4'd5,
        S_R         = 4'd6,
        S_CHECK     = 4'd7,
        S_DONE      = 4'd8,
        S_ERROR     = 4'd9
    } state_t;

    state_t                r_state, w_next;
    logic                  w_accept, w_done_ent;
    logic [MEM_ADDR_W-1:0] r_base, r_rd_addr;
    logic [c_CNT_W-1:0]    r_issued, r_beats;
    logic [c_GAP_W-1:0]    r_gap;
    logic [c_TMO_W-1:0]    r_tmo;
    logic [DATA_WIDTH-1:0] r_q0, r_q1, r_last_exp;
    logic [1:0]            r_cnt;
    logic                  r_pend, r_intr_d, r_intr_seen, r_error, r_done, r_stop;
    logic [15:0]           r_num, r_sc, r_right, r_wrong;
    logic [31:0]           r_last_det;
    logic [2:0]            w_occ;
    logic                  w_pop, w_issue, w_match;
    logic [15:0]           w_sc_next;

    function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign out_valid     = (r_cnt != 2'd0);
    assign out_data      = r_q0;
    assign w_pop         = out_valid && out_ready;
    // Reads in flight plus buffered words never exceed the two skid entries.
    assign w_occ         = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue       = (r_state == S_STREAM) && (r_issued != c_N) && (w_occ <= 3'd1);
    assign w_match       = (r_last_det == 32'(r_last_exp));
    assign w_sc_next     = f_sat_inc(r_sc);
    assign mem_addr      = r_rd_addr;
    assign m_axi_arvalid = (r_state == S_AR);
    assign m_axi_araddr  = (r_state == S_AR) ? 32'(RESULT_ADDR) : 32'd0;
    assign m_axi_rready  = (r_state == S_R);
    assign busy          = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign done          = r_done;
    assign error         = r_error;
    assign sample_count  = r_sc;
    assign right_count   = r_right;
    assign wrong_count   = r_wrong;
    assign last_detected = r_last_det;
    assign last_expected = r_last_exp;
    assign mismatch      = (r_state == S_CHECK) && !w_match;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done_ent = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (num_samples == 16'd0) begin
                        w_next     = S_DONE;
                        w_done_ent = 1'b1;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP:       if (r_gap == c_GAP_LAST) w_next = S_STREAM;
            S_STREAM:    if (w_pop && (r_beats == c_LAST_BEAT)) w_next = S_FETCH_EXP;
            S_FETCH_EXP: w_next = S_WAIT_INTR;
            S_WAIT_INTR: begin
                if (r_intr_seen)              w_next = S_AR;
                else if (r_tmo == c_TMO_LAST) w_next = S_ERROR;
            end
            S_AR:        if (m_axi_arready) w_next = S_R;
            S_R:         if (m_axi_rvalid) w_next = S_CHECK;
            S_CHECK: begin
                if ((w_sc_next == r_num) || (!w_match && r_stop)) begin
                    w_next     = S_DONE;
                    w_done_ent = 1'b1;
                end else begin
                    w_next = S_GAP;
                end
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_base      <= '0;
            r_rd_addr   <= '0;
            r_issued    <= '0;
            r_beats     <= '0;
            r_gap       <= '0;
            r_tmo       <= '0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_cnt       <= 2'd0;
            r_pend      <= 1'b0;
            r_intr_d    <= 1'b0;
            r_intr_seen <= 1'b0;
            r_error     <= 1'b0;
            r_done      <= 1'b0;
            r_stop      <= 1'b0;
            r_num       <= 16'd0;
            r_sc        <= 16'd0;
            r_right     <= 16'd0;
            r_wrong     <= 16'd0;
            r_last_det  <= 32'd0;
            r_last_exp  <= '0;
        end else begin
            r_intr_d <= intr;
            r_pend   <= w_issue;
            r_done   <= w_done_ent;

            if (w_issue) begin
                r_rd_addr <= r_rd_addr + MEM_ADDR_W'(1);
                r_issued  <= r_issued + c_CNT_W'(1);
            end
            if (w_pop) r_beats <= r_beats + c_CNT_W'(1);

            case ({r_pend, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_q0 <= mem_rdata;
                    else               r_q1 <= mem_rdata;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_q0 <= mem_rdata;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= mem_rdata;
                    end
                end
                default: ;
            endcase

            // The edge latch stays armed through FETCH_EXP so a fast network is not missed.
            if ((r_state == S_STREAM || r_state == S_FETCH_EXP || r_state == S_WAIT_INTR)
                && intr && !r_intr_d)
                r_intr_seen <= 1'b1;

            if (r_state == S_FETCH_EXP || r_state == S_WAIT_INTR) r_tmo <= r_tmo + c_TMO_W'(1);
            else                                                 r_tmo <= '0;

            if (w_accept) begin
                r_sc    <= 16'd0;
                r_right <= 16'd0;
                r_wrong <= 16'd0;
                r_error <= 1'b0;
                r_base  <= '0;
                r_num   <= num_samples;
                r_stop  <= stop_on_mismatch;
            end

            case (r_state)
                S_GAP: begin
                    r_intr_seen <= 1'b0;
                    if (r_gap == c_GAP_LAST) begin
                        r_gap     <= '0;
                        r_rd_addr <= r_base;
                        r_issued  <= '0;
                        r_beats   <= '0;
                    end else begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                S_FETCH_EXP: r_last_exp <= mem_rdata;
                S_WAIT_INTR: if (w_next == S_ERROR) r_error <= 1'b1;
                S_R:         if (m_axi_rvalid) r_last_det <= m_axi_rdata;
                S_CHECK: begin
                    r_sc <= w_sc_next;
                    if (w_match) r_right <= f_sat_inc(r_right);
                    else         r_wrong <= f_sat_inc(r_wrong);
                    r_base <= r_base + c_STRIDE;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_zynet_sample_runner.sv
`default_nettype none
// ============================================================================
// Module   : tb_zynet_sample_runner
// Brief    : Bench with sample memory, zyNet stand-in and beat scoreboard.
// Revision : 1.0
// ============================================================================
module tb_zynet_sample_runner;
    localparam int c_NI  = 4;
    localparam int c_TMO = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_samples = 16'd0;
    logic        stop_on_mismatch = 1'b0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        intr = 1'b0;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic [31:0] m_axi_rdata = 32'd0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        busy, done, error, mismatch;
    logic [15:0] sample_count, right_count, wrong_count, last_expected;
    logic [31:0] last_detected;

    zynet_sample_runner #(
        .DATA_WIDTH(16), .NUM_INPUTS(c_NI), .MEM_ADDR_W(8), .RESULT_ADDR(8),
        .GAP_CYCLES(3), .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_samples(num_samples),
        .stop_on_mismatch(stop_on_mismatch), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .intr(intr),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .busy(busy),
        .done(done), .error(error), .sample_count(sample_count),
        .right_count(right_count), .wrong_count(wrong_count),
        .last_detected(last_detected), .last_expected(last_expected), .mismatch(mismatch)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] mem [0:255];
    int          mem_init [0:9] = '{1, 2, 3, 4, 7, 5, 6, 7, 8, 3};
    always @(posedge clock) mem_rdata <= mem[mem_addr];

    bit ready_mode = 1'b0;
    bit pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int pidx = 0;
    always @(posedge clock) begin
        #1;
        if (ready_mode) begin
            out_ready = pat[pidx];
            pidx = (pidx + 1) % 6;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Network stand-in: intr rises one cycle after the last beat, drops after the read.
    logic [31:0] resp_q [$];
    bit intr_en = 1'b1;
    int net_beats = 0;
    int intr_cnt = 0;
    always @(negedge clock) begin
        if (reset) begin
            net_beats = 0; intr_cnt = 0; intr = 1'b0; m_axi_rvalid = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                net_beats++;
                if (net_beats == c_NI) begin
                    net_beats = 0;
                    if (intr_en) intr_cnt = 2;
                end
            end
            if (intr_cnt > 0) begin
                intr_cnt--;
                if (intr_cnt == 0) intr = 1'b1;
            end
            if (m_axi_rvalid) begin
                m_axi_rvalid = 1'b0;
                intr = 1'b0;
            end else if (m_axi_rready) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 32'hDEAD_BEEF;
            end
        end
    end

    logic [15:0] exp_beats [$];
    int beat_total = 0, done_cnt = 0, mm_cnt = 0, mm_sc = -1, max_addr = 0;
    bit busy_seen = 1'b0, prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                beat_total++;
                if (exp_beats.size() == 0) chk("beat_unexpected", {16'd0, out_data}, 32'hFFFF_FFFF);
                else                       chk("beat_data", {16'd0, out_data}, {16'd0, exp_beats.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (m_axi_arvalid && m_axi_arready) chk("araddr", m_axi_araddr, 32'd8);
            if (done) done_cnt++;
            if (busy) busy_seen = 1'b1;
            if (mismatch) begin
                mm_cnt++;
                mm_sc = int'(sample_count);
            end
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
    end

    typedef struct {
        int          num;
        bit          stop;
        bit          toggle;
        logic [31:0] r0, r1;
        int          streamed;
        int          sc, right, wrong;
        logic [31:0] det;
        logic [15:0] expw;
        int          mm, msc, maxa;
    } vec_t;

    vec_t vecs [0:4];

    task automatic clear_and_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        exp_beats.delete();
        resp_q.delete();
        beat_total = 0; done_cnt = 0; mm_cnt = 0; mm_sc = -1; max_addr = 0; busy_seen = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_start(input int n, input bit stop);
        num_samples = 16'(n);
        stop_on_mismatch = stop;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d_", idx);
        ready_mode = 1'b0;
        intr_en = 1'b1;
        clear_and_reset();
        for (int s = 0; s < v.streamed; s++)
            for (int i = 0; i < c_NI; i++) exp_beats.push_back(16'(mem_init[s * (c_NI + 1) + i]));
        resp_q.push_back(v.r0);
        resp_q.push_back(v.r1);
        ready_mode = v.toggle;
        pulse_start(v.num, v.stop);
        for (int c = 0; c < 600 && done_cnt == 0; c++) @(negedge clock);
        chk({p, "done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (20) @(negedge clock);
        chk({p, "done_pulses"}, 32'(done_cnt), 32'd1);
        chk({p, "sample_count"}, {16'd0, sample_count}, 32'(v.sc));
        chk({p, "right_count"}, {16'd0, right_count}, 32'(v.right));
        chk({p, "wrong_count"}, {16'd0, wrong_count}, 32'(v.wrong));
        chk({p, "last_detected"}, last_detected, v.det);
        chk({p, "last_expected"}, {16'd0, last_expected}, {16'd0, v.expw});
        chk({p, "mismatch_pulses"}, 32'(mm_cnt), 32'(v.mm));
        chk({p, "mismatch_sample"}, 32'(mm_sc), 32'(v.msc));
        chk({p, "beats"}, 32'(beat_total), 32'(v.streamed * c_NI));
        chk({p, "beats_left"}, 32'(exp_beats.size()), 32'd0);
        chk({p, "max_mem_addr"}, 32'(max_addr), 32'(v.maxa));
        chk({p, "busy"}, {31'd0, busy}, 32'd0);
        chk({p, "error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        for (int i = 0; i < 256; i++) mem[i] = (i < 10) ? 16'(mem_init[i]) : 16'h00EE;

        vecs[0] = '{num:2, stop:0, toggle:0, r0:7, r1:3, streamed:2, sc:2, right:2, wrong:0,
                    det:3, expw:3, mm:0, msc:-1, maxa:9};
        vecs[1] = '{num:2, stop:0, toggle:0, r0:7, r1:9, streamed:2, sc:2, right:1, wrong:1,
                    det:9, expw:3, mm:1, msc:1, maxa:9};
        vecs[2] = '{num:2, stop:1, toggle:0, r0:5, r1:3, streamed:1, sc:1, right:0, wrong:1,
                    det:5, expw:7, mm:1, msc:0, maxa:4};
        vecs[3] = '{num:2, stop:0, toggle:1, r0:7, r1:3, streamed:2, sc:2, right:2, wrong:0,
                    det:3, expw:3, mm:0, msc:-1, maxa:9};
        vecs[4] = '{num:2, stop:1, toggle:0, r0:7, r1:3, streamed:2, sc:2, right:2, wrong:0,
                    det:3, expw:3, mm:0, msc:-1, maxa:9};

        repeat (3) @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        chk("rst_counts", {sample_count, right_count | wrong_count}, 32'd0);
        chk("rst_axi", {m_axi_araddr[29:0], m_axi_arvalid, m_axi_rready}, 32'd0);
        chk("rst_last", last_detected | {16'd0, last_expected} | {24'd0, mem_addr}, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

        // Timeout: intr never rises for the only sample.
        ready_mode = 1'b0;
        intr_en = 1'b0;
        clear_and_reset();
        for (int i = 0; i < c_NI; i++) exp_beats.push_back(16'(mem_init[i]));
        pulse_start(1, 1'b0);
        b = 0;
        for (int c = 0; c < 200 && b < c_NI; c++) begin
            @(negedge clock);
            if (out_valid && out_ready) b++;
        end
        chk("tmo_beats", 32'(b), 32'(c_NI));
        repeat (c_TMO) @(negedge clock);
        chk("tmo_before", {30'd0, error, busy}, 32'd1);
        @(negedge clock);
        chk("tmo_after", {30'd0, error, busy}, 32'd2);
        chk("tmo_counts", {sample_count, right_count | wrong_count}, 32'd0);
        repeat (5) @(negedge clock);
        chk("tmo_sticky", {31'd0, error}, 32'd1);
        pulse_start(0, 1'b0);
        @(negedge clock);
        chk("tmo_cleared", {31'd0, error}, 32'd0);
        chk("tmo_restart_done", 32'(done_cnt), 32'd1);
        intr_en = 1'b1;

        // Reset while streaming, after the second beat.
        clear_and_reset();
        for (int i = 0; i < 10; i++) exp_beats.push_back(16'(mem_init[i]));
        resp_q.push_back(32'd7);
        resp_q.push_back(32'd3);
        pulse_start(2, 1'b0);
        b = 0;
        for (int c = 0; c < 200 && b < 2; c++) begin
            @(negedge clock);
            if (out_valid && out_ready) b++;
        end
        chk("rstmid_beats", 32'(b), 32'd2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_counts", {sample_count, right_count | wrong_count}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        exp_beats.delete();
        beat_total = 0; done_cnt = 0; busy_seen = 1'b0;
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("rstmid_no_beats", 32'(beat_total), 32'd0);
        chk("rstmid_no_ar", {31'd0, m_axi_arvalid}, 32'd0);
        pulse_start(0, 1'b0);
        repeat (5) @(negedge clock);
        chk("zero_done", 32'(done_cnt), 32'd1);
        chk("zero_busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("zero_beats", 32'(beat_total), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
